stoppuhr_steuerung: RTL and testbench

- Stopwatch control and time-base stage, downstream of the debounced push-button edge detectors in the Stopuhr design.
- Consumes two single-cycle button-press pulses (start/stop, lap/reset) and runs a 4-state FSM.
- Maintains a BCD time count MM:SS.hh and presents a registered display value, optionally frozen for lap display, to the 7-segment driver.

---
 rtl/stoppuhr_pkg.sv | 22 ++
 rtl/stoppuhr_steuerung_if.sv | 27 ++
 rtl/stoppuhr_steuerung_bcd_ziffer.sv | 37 +++
 rtl/stoppuhr_steuerung.sv | 145 ++++++++++++++
 tb/tb_stoppuhr_steuerung.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/stoppuhr_pkg.sv
// Shared definitions for the stopwatch control: state encoding, BCD digit
// limits and the prescaler divide ratio.
package stoppuhr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } zustand_t;

  localparam int          ZIFFER_W  = 4;
  localparam logic [3:0]  BCD_MAX_9 = 4'd9;
  localparam logic [3:0]  BCD_MAX_5 = 4'd5;

  // Clock cycles per hundredth tick; callers keep the ratio integral and >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stoppuhr_steuerung_if.sv
// Button pulses in, BCD display value and status flags out.
// master: the side that issues pulses and watches the display.
// slave : the stopwatch control itself.
interface stoppuhr_steuerung_if;

  logic       puls_start_stop;
  logic       puls_lap_reset;
  logic [7:0] anz_hundertstel;
  logic [7:0] anz_sekunden;
  logic [7:0] anz_minuten;
  logic       laeuft;
  logic       lap_aktiv;
  logic       ueberlauf;

  modport master (
    output puls_start_stop, puls_lap_reset,
    input  anz_hundertstel, anz_sekunden, anz_minuten,
    input  laeuft, lap_aktiv, ueberlauf
  );

  modport slave (
    input  puls_start_stop, puls_lap_reset,
    output anz_hundertstel, anz_sekunden, anz_minuten,
    output laeuft, lap_aktiv, ueberlauf
  );

endinterface

// File: rtl/stoppuhr_steuerung_bcd_ziffer.sv
// One BCD digit counter. Counts 0..max_i on inc_i, wraps to 0 and raises a
// carry in the same cycle it wraps. Any out-of-range value also wraps to 0,
// so the digit can never leave the BCD range.
module bcd_ziffer
  import stoppuhr_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [ZIFFER_W-1:0] max_i,
  output logic [ZIFFER_W-1:0] ziffer_o,
  output logic                carry_o
);

  logic [ZIFFER_W-1:0] ziffer_q, ziffer_d;

  // Next digit value: clear wins over increment.
  always_comb begin
    ziffer_d = ziffer_q;
    if (clr_i) begin
      ziffer_d = '0;
    end else if (inc_i) begin
      ziffer_d = (ziffer_q >= max_i) ? '0 : ZIFFER_W'(ziffer_q + 1'b1);
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (reset) ziffer_q <= '0;
    else       ziffer_q <= ziffer_d;
  end

  assign ziffer_o = ziffer_q;
  assign carry_o  = inc_i && (ziffer_q == max_i);

endmodule

// File: rtl/stoppuhr_steuerung.sv
// Stopwatch control: IDLE/RUN/STOP/LAP state machine, hundredths prescaler,
// BCD time count MM:SS.hh and the registered (lap-freezable) display value.
// Build option STOPUHR_SATURATE_EN: at 59:59.99 the count saturates and the
// watch drops to STOP instead of wrapping to 00:00.00.
module stoppuhr_steuerung
  import stoppuhr_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 100
) (
  input logic                 clk,
  input logic                 reset,
  stoppuhr_steuerung_if.slave sw_if
);

  localparam int unsigned   DIV       = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned   PW        = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  zustand_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    anz_h_q, anz_h_d;
  logic [7:0]    anz_s_q, anz_s_d;
  logic [7:0]    anz_m_q, anz_m_d;
  logic          ueberlauf_q, ueberlauf_d;

  logic start_stop, lap_reset;
  logic zaehlt, tick, clr_zaehler, inc_kette, ovf_set, sat_stop;
  logic laeuft, lap_aktiv;
  logic [3:0] h0, h1, s0, s1, m0, m1;
  logic c_h0, c_h1, c_s0, c_s1, c_m0, c_m1;

  assign start_stop = sw_if.puls_start_stop;
  assign lap_reset  = sw_if.puls_lap_reset;

  assign zaehlt = (state_q == RUN) || (state_q == LAP);
  assign tick   = zaehlt && (presc_q == PRESC_MAX);

  // Counters, prescaler and overflow flag are cleared while idle and on the
  // STOP -> IDLE edge (lap/reset alone; start/stop has priority).
  assign clr_zaehler = (state_q == IDLE) ||
                       ((state_q == STOP) && lap_reset && !start_stop);

`ifdef STOPUHR_SATURATE_EN
  logic alle_max;
  assign alle_max  = (h0 == BCD_MAX_9) && (h1 == BCD_MAX_9) &&
                     (s0 == BCD_MAX_9) && (s1 == BCD_MAX_5) &&
                     (m0 == BCD_MAX_9) && (m1 == BCD_MAX_5);
  assign inc_kette = tick && !alle_max;
  assign ovf_set   = tick && alle_max;
  assign sat_stop  = tick && alle_max;
`else
  assign inc_kette = tick;
  assign ovf_set   = c_m1;
  assign sat_stop  = 1'b0;
`endif

  bcd_ziffer u_h0 (.clk(clk), .reset(reset), .clr_i(clr_zaehler), .inc_i(inc_kette),
                   .max_i(BCD_MAX_9), .ziffer_o(h0), .carry_o(c_h0));
  bcd_ziffer u_h1 (.clk(clk), .reset(reset), .clr_i(clr_zaehler), .inc_i(c_h0),
                   .max_i(BCD_MAX_9), .ziffer_o(h1), .carry_o(c_h1));
  bcd_ziffer u_s0 (.clk(clk), .reset(reset), .clr_i(clr_zaehler), .inc_i(c_h1),
                   .max_i(BCD_MAX_9), .ziffer_o(s0), .carry_o(c_s0));
  bcd_ziffer u_s1 (.clk(clk), .reset(reset), .clr_i(clr_zaehler), .inc_i(c_s0),
                   .max_i(BCD_MAX_5), .ziffer_o(s1), .carry_o(c_s1));
  bcd_ziffer u_m0 (.clk(clk), .reset(reset), .clr_i(clr_zaehler), .inc_i(c_s1),
                   .max_i(BCD_MAX_9), .ziffer_o(m0), .carry_o(c_m0));
  bcd_ziffer u_m1 (.clk(clk), .reset(reset), .clr_i(clr_zaehler), .inc_i(c_m0),
                   .max_i(BCD_MAX_5), .ziffer_o(m1), .carry_o(c_m1));

  // Next state and status flags; start/stop beats lap/reset, saturation forces STOP.
  always_comb begin
    state_d   = state_q;
    laeuft    = 1'b0;
    lap_aktiv = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) state_d = RUN;
      end
      RUN: begin
        laeuft = 1'b1;
        if (start_stop)     state_d = STOP;
        else if (lap_reset) state_d = LAP;
      end
      LAP: begin
        laeuft    = 1'b1;
        lap_aktiv = 1'b1;
        if (start_stop)     state_d = STOP;
        else if (lap_reset) state_d = RUN;
      end
      STOP: begin
        if (start_stop)     state_d = RUN;
        else if (lap_reset) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sat_stop) state_d = STOP;
  end

  // Prescaler, display and overflow next values. The display follows the
  // live count one cycle late except while in LAP, where it holds.
  always_comb begin
    presc_d     = presc_q;
    anz_h_d     = anz_h_q;
    anz_s_d     = anz_s_q;
    anz_m_d     = anz_m_q;
    ueberlauf_d = ueberlauf_q;
    if (clr_zaehler)  presc_d = '0;
    else if (zaehlt)  presc_d = tick ? '0 : PW'(presc_q + 1'b1);
    if (state_q != LAP) begin
      anz_h_d = {h1, h0};
      anz_s_d = {s1, s0};
      anz_m_d = {m1, m0};
    end
    if (clr_zaehler)  ueberlauf_d = 1'b0;
    else if (ovf_set) ueberlauf_d = 1'b1;
  end

  // State, prescaler, display and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      anz_h_q     <= '0;
      anz_s_q     <= '0;
      anz_m_q     <= '0;
      ueberlauf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      anz_h_q     <= anz_h_d;
      anz_s_q     <= anz_s_d;
      anz_m_q     <= anz_m_d;
      ueberlauf_q <= ueberlauf_d;
    end
  end

  assign sw_if.anz_hundertstel = anz_h_q;
  assign sw_if.anz_sekunden    = anz_s_q;
  assign sw_if.anz_minuten     = anz_m_q;
  assign sw_if.laeuft          = laeuft;
  assign sw_if.lap_aktiv       = lap_aktiv;
  assign sw_if.ueberlauf       = ueberlauf_q;

endmodule

// File: tb/tb_stoppuhr_steuerung.sv
// Directed bench for stoppuhr_steuerung with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// Stimulus queues expected display/flag vectors; a monitor compares them on
// the falling edge following the push.
module tb_stoppuhr_steuerung;

  logic clk;
  logic reset;

  stoppuhr_steuerung_if sw_if ();

  stoppuhr_steuerung #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .sw_if (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {minuten, sekunden, hundertstel, laeuft, lap_aktiv, ueberlauf}
  logic [26:0] erw_q[$];
  string       name_q[$];
  int          n_vec  = 0;
  int          n_err  = 0;
  bit          fertig = 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic puls_ss;
    sw_if.puls_start_stop = 1'b1;
    step(1);
    sw_if.puls_start_stop = 1'b0;
  endtask

  task automatic puls_lr;
    sw_if.puls_lap_reset = 1'b1;
    step(1);
    sw_if.puls_lap_reset = 1'b0;
  endtask

  task automatic puls_beide;
    sw_if.puls_start_stop = 1'b1;
    sw_if.puls_lap_reset  = 1'b1;
    step(1);
    sw_if.puls_start_stop = 1'b0;
    sw_if.puls_lap_reset  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [7:0] m, input logic [7:0] s,
                     input logic [7:0] h, input logic lf, input logic la, input logic ov);
    erw_q.push_back({m, s, h, lf, la, ov});
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin : monitor
    logic [26:0] erw;
    logic [26:0] ist;
    string       nm;
    forever begin
      @(negedge clk);
      while (erw_q.size() > 0) begin
        erw = erw_q.pop_front();
        nm  = name_q.pop_front();
        ist = {sw_if.anz_minuten, sw_if.anz_sekunden, sw_if.anz_hundertstel,
               sw_if.laeuft, sw_if.lap_aktiv, sw_if.ueberlauf};
        n_vec++;
        if (ist !== erw) begin
          n_err++;
          $display("FAIL %s: got %h:%h.%h laeuft=%b lap=%b ovf=%b, expected %h:%h.%h laeuft=%b lap=%b ovf=%b",
                   nm, ist[26:19], ist[18:11], ist[10:3], ist[2], ist[1], ist[0],
                   erw[26:19], erw[18:11], erw[10:3], erw[2], erw[1], erw[0]);
        end
      end
      if (fertig) begin
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin : stimulus
    reset                 = 1'b1;
    sw_if.puls_start_stop = 1'b0;
    sw_if.puls_lap_reset  = 1'b0;
    step(3);
    reset = 1'b0;

    step(100);
    chk("reset_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    if (sw_if.anz_hundertstel !== 8'h00) begin
      n_err++;
      $display("FAIL reset_idle_direct: got %h, expected 00", sw_if.anz_hundertstel);
    end

    puls_lr;
    step(20);
    chk("lap_in_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Run 25 hundredths, stop, resume with the prescaler phase preserved.
    puls_ss;
    step(251);
    chk("run_25", 8'h00, 8'h00, 8'h25, 1'b1, 1'b0, 1'b0);
    if (sw_if.laeuft !== 1'b1) begin
      n_err++;
      $display("FAIL run_25_direct: laeuft=%b, expected 1", sw_if.laeuft);
    end
    puls_ss;
    step(100);
    chk("stop_hold", 8'h00, 8'h00, 8'h25, 1'b0, 1'b0, 1'b0);
    puls_ss;
    step(9);
    chk("resume_26", 8'h00, 8'h00, 8'h26, 1'b1, 1'b0, 1'b0);
    puls_ss;
    puls_lr;
    step(1);
    chk("stop_to_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Lap: freeze at 12 while the live count reaches 30.
    puls_ss;
    step(120);
    puls_lr;
    step(180);
    chk("lap_frozen", 8'h00, 8'h00, 8'h12, 1'b1, 1'b1, 1'b0);
    if (sw_if.lap_aktiv !== 1'b1) begin
      n_err++;
      $display("FAIL lap_frozen_direct: lap_aktiv=%b, expected 1", sw_if.lap_aktiv);
    end
    puls_lr;
    chk("lap_exit_edge", 8'h00, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0);
    step(1);
    chk("lap_release", 8'h00, 8'h00, 8'h30, 1'b1, 1'b0, 1'b0);

    // Both pulses together: start/stop wins.
    puls_beide;
    chk("both_run_stop", 8'h00, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0);
    step(20);
    chk("both_hold", 8'h00, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0);
    puls_beide;
    chk("both_stop_run", 8'h00, 8'h00, 8'h30, 1'b1, 1'b0, 1'b0);
    puls_ss;
    puls_lr;
    step(1);
    chk("idle_again", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Overflow: preload 59:59.98 while stopped, then run two ticks.
    puls_ss;
    puls_ss;
    force dut.u_h0.ziffer_q = 4'd8;
    force dut.u_h1.ziffer_q = 4'd9;
    force dut.u_s0.ziffer_q = 4'd9;
    force dut.u_s1.ziffer_q = 4'd5;
    force dut.u_m0.ziffer_q = 4'd9;
    force dut.u_m1.ziffer_q = 4'd5;
    step(1);
    release dut.u_h0.ziffer_q;
    release dut.u_h1.ziffer_q;
    release dut.u_s0.ziffer_q;
    release dut.u_s1.ziffer_q;
    release dut.u_m0.ziffer_q;
    release dut.u_m1.ziffer_q;
    step(1);
    chk("preload", 8'h59, 8'h59, 8'h98, 1'b0, 1'b0, 1'b0);
    puls_ss;
    step(10);
    chk("pre_wrap", 8'h59, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0);
    step(10);
`ifdef STOPUHR_SATURATE_EN
    chk("saturate", 8'h59, 8'h59, 8'h99, 1'b0, 1'b0, 1'b1);
    step(50);
    chk("ovf_sticky", 8'h59, 8'h59, 8'h99, 1'b0, 1'b0, 1'b1);
`else
    chk("wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    step(50);
    puls_ss;
    chk("ovf_sticky", 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1);
`endif
    puls_lr;
    step(1);
    chk("ovf_clear", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    if (sw_if.ueberlauf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear_direct: ueberlauf=%b, expected 0", sw_if.ueberlauf);
    end

    // Reset mid-run with a simultaneous start/stop pulse.
    puls_ss;
    step(1501);
    chk("pre_reset", 8'h00, 8'h01, 8'h50, 1'b1, 1'b0, 1'b0);
    reset                 = 1'b1;
    sw_if.puls_start_stop = 1'b1;
    step(1);
    reset                 = 1'b0;
    sw_if.puls_start_stop = 1'b0;
    chk("reset_abort", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    if (sw_if.laeuft !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort_direct: laeuft=%b, expected 0", sw_if.laeuft);
    end
    step(20);
    chk("reset_pulse_ignored", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    fertig = 1'b1;
  end

endmodule
